mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 16, address width in bits.
REQ-002 The block SHALL have parameter DW, default 16, data width in bits.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, the maximum number of consecutive port-0 grants while port 1 waits (fixed-priority mode only).
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have ports m0_req, m1_req, input, 1 each: access request, held until granted.
REQ-007 The block SHALL have ports m0_we, m1_we, input, 1 each: 1 = write, 0 = read.
REQ-008 The block SHALL have ports m0_addr, m1_addr, input, AW each: access address.
REQ-009 The block SHALL have ports m0_wdata, m1_wdata, input, DW each: write data.
REQ-010 The block SHALL have ports m0_gnt, m1_gnt, output, 1 each: combinational grant; the request transfers at the edge where req && gnt.
REQ-011 The block SHALL have ports m0_rvalid, m1_rvalid, output, 1 each: one-cycle pulse marking valid read data.
REQ-012 The block SHALL have ports m0_rdata, m1_rdata, output, DW each: read return data.
REQ-013 The block SHALL have port mem_addr, output, AW: registered RAM address.
REQ-014 The block SHALL have port mem_din, output, DW: registered RAM write data.
REQ-015 The block SHALL have port mem_we, output, 1: registered RAM write enable.
REQ-016 The block SHALL have port mem_dout, input, DW: RAM read data, valid one cycle after the address is presented.

Function
REQ-017 At most one of m0_gnt and m1_gnt SHALL be high in any cycle, and neither SHALL be high unless its req is high.
REQ-018 When only one port requests, that port SHALL be granted in the same cycle.
REQ-019 The FSM SHALL have states IDLE, ACC0 and ACC1, naming the owner of the current RAM cycle; it moves to ACCn after a port-n handshake and to IDLE when no handshake occurs.
REQ-020 After a handshake at edge E, mem_addr, mem_din and mem_we SHALL carry the transfer during cycle E+1; mem_we SHALL be 0 in IDLE.
REQ-021 For a read handshake at edge E, mN_rvalid SHALL pulse in cycle E+2 with mN_rdata = mem_dout; the read latency is exactly 2 cycles.
REQ-022 Back-to-back handshakes SHALL be accepted every cycle with no bubbles, and read returns SHALL stay in order and be tagged to the correct port.
REQ-023 Writes SHALL produce no rvalid.
REQ-024 mN_rdata SHALL hold its last value when rvalid is low.
REQ-025 A simultaneous request from both ports SHALL be resolved by the REQ-028/REQ-029 policy; the loser's request SHALL remain pending with no loss.

Reset
REQ-026 While reset is high, gnt, rvalid and mem_we SHALL be 0; mem_addr, mem_din and rdata SHALL be 0; the FSM SHALL be in IDLE; the priority pointer SHALL select port 0; the burst counter SHALL be 0.
REQ-027 A reset asserted mid-operation SHALL discard any in-flight read (no rvalid afterwards), and the first grant after reset deassertion SHALL be possible in the first cycle.

Configuration
REQ-028 With ARB_ROUND_ROBIN_EN defined, contention SHALL go to the port not granted most recently; after reset the pointer favours port 0; MAX_BURST is ignored.
REQ-029 Without ARB_ROUND_ROBIN_EN, port 0 SHALL have fixed priority, except that after MAX_BURST consecutive port-0 grants while m1_req is high, port 1 SHALL receive the next grant; the counter clears on any port-1 grant or when m1_req is low.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the AW/DW defaults, the FSM state enum (IDLE, ACC0, ACC1) and the port-index type.
REQ-031 Grant selection SHALL be one sub-module, arb_pick (inputs: reqs, pointer, burst_sat; output: one-hot grant); the datapath and read-return pipeline SHALL stay in mem_arbiter.

Verification
REQ-032 The bench SHALL check: m0 writes 0x00A5 to 0x0010, then m1 reads 0x0010 -> m1_rvalid 2 cycles after the read handshake, m1_rdata = 0x00A5, m0_rvalid stays 0.
REQ-033 The bench SHALL check: both ports request reads of 0x0001/0x0002 continuously for 8 cycles (round-robin build) -> grants alternate 0,1,0,1; 8 rvalids, in order, correctly routed.
REQ-034 The bench SHALL check: fixed-priority build, MAX_BURST=4, both ports hold req -> grant pattern 0,0,0,0,1,0,0,0,0,1.
REQ-035 The bench SHALL check: m0 issues reads on 4 consecutive cycles -> 4 gnts, 4 consecutive rvalids starting 2 cycles after the first handshake.
REQ-036 The bench SHALL check: reset asserted one cycle after a read handshake -> no rvalid; all outputs 0; a grant is possible in the first cycle after reset drops.
REQ-037 The bench SHALL check: m1 alone holds req for 3 cycles -> m1_gnt high in all 3 cycles, m0_gnt never high.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 16;

  // Owner of the RAM cycle currently on mem_addr/mem_din/mem_we
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } state_t;

  typedef logic port_idx_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester ports and RAM-side signals for mem_arbiter.
// master = requesters plus RAM model, slave = the arbiter.
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) ();

  logic          m0_req;
  logic          m1_req;
  logic          m0_we;
  logic          m1_we;
  logic [AW-1:0] m0_addr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m1_wdata;
  logic          m0_gnt;
  logic          m1_gnt;
  logic          m0_rvalid;
  logic          m1_rvalid;
  logic [DW-1:0] m0_rdata;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output mem_dout,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    input  mem_addr, mem_din, mem_we
  );

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  mem_dout,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    output mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Two-way grant selector: a lone requester wins outright, contention goes
// to burst_sat ? port 1 : pointer.
module arb_pick import mem_arb_pkg::*; (
  input  logic [1:0] reqs,
  input  port_idx_t  pointer,
  input  logic       burst_sat,
  output logic [1:0] grant
);

  port_idx_t favour;

  always_comb begin
    favour = burst_sat ? 1'b1 : pointer;
    grant  = reqs;
    if (reqs == 2'b11) begin
      grant = favour ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-RAM arbiter with a 2-cycle read-return pipeline.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed
// port-0 priority with a MAX_BURST starvation guard for port 1.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  logic [1:0]    reqs;
  logic [1:0]    pick;
  logic [1:0]    gnt;
  port_idx_t     pointer;
  logic          burst_sat;
  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic          we_q;
  logic          rd_cycle;
  logic          rvalid0_q;
  logic          rvalid1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  assign reqs = {bus.m1_req, bus.m0_req};

  arb_pick u_pick (
    .reqs      (reqs),
    .pointer   (pointer),
    .burst_sat (burst_sat),
    .grant     (pick)
  );

  // Grants are combinational but forced low while reset is held
  assign gnt        = reset ? 2'b00 : pick;
  assign bus.m0_gnt = gnt[0];
  assign bus.m1_gnt = gnt[1];

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer names the port that did not win the most recent grant
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer <= 1'b0;
    end else if (gnt[0]) begin
      pointer <= 1'b1;
    end else if (gnt[1]) begin
      pointer <= 1'b0;
    end
  end

  assign burst_sat = 1'b0;
`else
  localparam int unsigned CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  logic [CW-1:0] burst_cnt;

  // Consecutive port-0 wins while port 1 is waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (!bus.m1_req || gnt[1]) begin
      burst_cnt <= '0;
    end else if (gnt[0] && !burst_sat) begin
      burst_cnt <= CW'(burst_cnt + 1'b1);
    end
  end

  assign burst_sat = (burst_cnt >= CW'(MAX_BURST));
  assign pointer   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = IDLE;
    if (gnt[0]) begin
      state_nx = ACC0;
    end else if (gnt[1]) begin
      state_nx = ACC1;
    end
  end

  // RAM request register: winner's transfer appears the cycle after handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
    end else begin
      we_q <= (gnt[0] & bus.m0_we) | (gnt[1] & bus.m1_we);
      if (gnt[1]) begin
        addr_q <= bus.m1_addr;
        din_q  <= bus.m1_wdata;
      end else if (gnt[0]) begin
        addr_q <= bus.m0_addr;
        din_q  <= bus.m0_wdata;
      end
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.mem_we   = we_q;

  // A read owned by state this cycle returns mem_dout next cycle
  assign rd_cycle = (state != IDLE) && !we_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rd_cycle && (state == ACC0);
      rvalid1_q <= rd_cycle && (state == ACC1);
      if (rvalid0_q) begin
        rdata0_q <= bus.mem_dout;
      end
      if (rvalid1_q) begin
        rdata1_q <= bus.mem_dout;
      end
    end
  end

  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = rvalid0_q ? bus.mem_dout : rdata0_q;
  assign bus.m1_rdata  = rvalid1_q ? bus.mem_dout : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1-cycle-latency RAM model.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  logic [15:0] ram [0:255];

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.AW(16), .DW(16), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read-before-write, data valid the cycle after the address
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr[7:0]];
  end

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {8'hA0, a[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clr_inputs();
    bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
    bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_wdata = 0; bus.m1_wdata = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Lock-step read sequence: pat bit c gives expected winner of cycle c
  task automatic run_seq(input string tag, input int n, input bit on0, input bit on1,
                         input logic [15:0] pat, input logic [15:0] a0_in,
                         input logic [15:0] a1_in, input bit inc);
    logic [15:0] a0, a1;
    bit          hv [0:16];
    bit          hp [0:16];
    logic [15:0] hd [0:16];
    bit          p;
    a0 = a0_in;
    a1 = a1_in;
    for (int c = 0; c <= n; c++) begin
      hv[c] = 1'b0; hp[c] = 1'b0; hd[c] = '0;
      bus.m0_req = (c < n) && on0; bus.m0_we = 1'b0; bus.m0_addr = a0;
      bus.m1_req = (c < n) && on1; bus.m1_we = 1'b0; bus.m1_addr = a1;
      #1;
      p = (c < n) ? pat[c] : 1'b0;
      chk($sformatf("%s gnt0 c%0d", tag, c), 32'(bus.m0_gnt), 32'((c < n) && !p));
      chk($sformatf("%s gnt1 c%0d", tag, c), 32'(bus.m1_gnt), 32'((c < n) && p));
      if (c < n) begin
        hv[c] = 1'b1;
        hp[c] = p;
        hd[c] = init_val(p ? a1 : a0);
        if (inc) begin
          if (p) a1 = a1 + 16'd1;
          else   a0 = a0 + 16'd1;
        end
      end
      @(posedge clk);
      #1;
      if (c >= 1 && hv[c-1]) begin
        chk($sformatf("%s rvalid0 c%0d", tag, c), 32'(bus.m0_rvalid), 32'(!hp[c-1]));
        chk($sformatf("%s rvalid1 c%0d", tag, c), 32'(bus.m1_rvalid), 32'(hp[c-1]));
        chk($sformatf("%s rdata c%0d", tag, c),
            32'(hp[c-1] ? bus.m1_rdata : bus.m0_rdata), 32'(hd[c-1]));
      end else begin
        chk($sformatf("%s no rvalid c%0d", tag, c),
            32'({bus.m1_rvalid, bus.m0_rvalid}), 32'(0));
      end
    end
    clr_inputs();
  endtask

  typedef struct packed {
    logic        r0, r1, w0, w1;
    logic [15:0] a0, a1, d0, d1;
    logic        g0, g1, mwe;
    logic [15:0] maddr, mdin;
  } vec_t;

  vec_t vecs [5];

`ifdef ARB_ROUND_ROBIN_EN
  localparam int          CONT_N   = 8;
  localparam logic [15:0] CONT_PAT = 16'h00AA;
`else
  localparam int          CONT_N   = 10;
  localparam logic [15:0] CONT_PAT = 16'h0210;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 256; i++) ram[i] = init_val(16'(i));

    //              r0 r1 w0 w1 a0       a1       d0       d1       g0 g1 mwe maddr    mdin
    vecs[0] = '{1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b0,16'h0000,16'h0000};
    vecs[1] = '{1'b1,1'b0,1'b1,1'b0,16'h0010,16'h0000,16'h00A5,16'h0000,1'b1,1'b0,1'b1,16'h0010,16'h00A5};
    vecs[2] = '{1'b0,1'b1,1'b0,1'b1,16'h0000,16'h0020,16'h0000,16'h1234,1'b0,1'b1,1'b1,16'h0020,16'h1234};
    vecs[3] = '{1'b1,1'b1,1'b0,1'b1,16'h0030,16'h0040,16'h0000,16'hBEEF,1'b1,1'b0,1'b0,16'h0030,16'h0000};
    vecs[4] = '{1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0050,16'h0000,16'h0000,1'b0,1'b1,1'b0,16'h0050,16'h0000};

    // Reset state, with both requests raised to show reset masks grants
    reset = 1'b1;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    #1;
    chk("reset gnt", 32'({bus.m1_gnt, bus.m0_gnt}), 32'(0));
    chk("reset rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'(0));
    chk("reset mem_we", 32'(bus.mem_we), 32'(0));
    chk("reset mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("reset mem_din", 32'(bus.mem_din), 32'(0));
    chk("reset rdata", 32'({bus.m1_rdata, bus.m0_rdata}), 32'(0));
    clr_inputs();

    // Single-cycle grant and RAM-request vectors, each from a fresh reset
    for (int v = 0; v < 5; v++) begin
      do_reset();
      bus.m0_req = vecs[v].r0; bus.m1_req = vecs[v].r1;
      bus.m0_we = vecs[v].w0;  bus.m1_we = vecs[v].w1;
      bus.m0_addr = vecs[v].a0; bus.m1_addr = vecs[v].a1;
      bus.m0_wdata = vecs[v].d0; bus.m1_wdata = vecs[v].d1;
      #1;
      chk($sformatf("vec%0d gnt0", v), 32'(bus.m0_gnt), 32'(vecs[v].g0));
      chk($sformatf("vec%0d gnt1", v), 32'(bus.m1_gnt), 32'(vecs[v].g1));
      @(posedge clk);
      #1;
      clr_inputs();
      chk($sformatf("vec%0d mem_we", v), 32'(bus.mem_we), 32'(vecs[v].mwe));
      chk($sformatf("vec%0d mem_addr", v), 32'(bus.mem_addr), 32'(vecs[v].maddr));
      chk($sformatf("vec%0d mem_din", v), 32'(bus.mem_din), 32'(vecs[v].mdin));
    end

    // m0 writes 0x00A5 to 0x0010, then m1 reads it back
    do_reset();
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 16'h0010; bus.m0_wdata = 16'h00A5;
    #1 chk("wr gnt0", 32'(bus.m0_gnt), 32'(1));
    @(posedge clk); #1;
    chk("wr mem_we", 32'(bus.mem_we), 32'(1));
    chk("wr mem_din", 32'(bus.mem_din), 32'h00A5);
    clr_inputs();
    bus.m1_req = 1; bus.m1_addr = 16'h0010;
    #1 chk("rd gnt1", 32'(bus.m1_gnt), 32'(1));
    @(posedge clk); #1;
    clr_inputs();
    chk("rd E+1 mem_addr", 32'(bus.mem_addr), 32'h0010);
    chk("rd E+1 mem_we", 32'(bus.mem_we), 32'(0));
    chk("rd E+1 no rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'(0));
    @(posedge clk); #1;
    chk("rd E+2 m1_rvalid", 32'(bus.m1_rvalid), 32'(1));
    chk("rd E+2 m1_rdata", 32'(bus.m1_rdata), 32'h00A5);
    chk("rd E+2 m0_rvalid", 32'(bus.m0_rvalid), 32'(0));
    @(posedge clk); #1;
    chk("rd E+3 m1_rvalid", 32'(bus.m1_rvalid), 32'(0));
    chk("rd E+3 m1_rdata hold", 32'(bus.m1_rdata), 32'h00A5);
    chk("rd E+3 m0_rvalid", 32'(bus.m0_rvalid), 32'(0));

    // Contention: alternating (round robin) or 4+1 burst pattern (fixed)
    do_reset();
    run_seq("cont", CONT_N, 1'b1, 1'b1, CONT_PAT, 16'h0001, 16'h0002, 1'b0);

    // m0 alone, four back-to-back reads
    do_reset();
    run_seq("m0b2b", 4, 1'b1, 1'b0, 16'h0000, 16'h0004, 16'h0000, 1'b1);

    // m1 alone, held for three cycles
    do_reset();
    run_seq("m1only", 3, 1'b0, 1'b1, 16'h0007, 16'h0000, 16'h0008, 1'b1);

    // Reset one cycle after a read handshake discards the read
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 16'h0003;
    #1 chk("rst gnt0", 32'(bus.m0_gnt), 32'(1));
    @(posedge clk); #1;
    clr_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'(0));
    chk("rst mem_we", 32'(bus.mem_we), 32'(0));
    chk("rst mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("rst mem_din", 32'(bus.mem_din), 32'(0));
    chk("rst rdata", 32'({bus.m1_rdata, bus.m0_rdata}), 32'(0));
    @(posedge clk); #1;
    chk("rst rvalid 2", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'(0));
    reset = 1'b0;
    bus.m1_req = 1; bus.m1_addr = 16'h0009;
    #1 chk("post-rst gnt1", 32'(bus.m1_gnt), 32'(1));
    @(posedge clk); #1;
    clr_inputs();
    chk("post-rst no rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'(0));
    @(posedge clk); #1;
    chk("post-rst m1_rvalid", 32'(bus.m1_rvalid), 32'(1));
    chk("post-rst m1_rdata", 32'(bus.m1_rdata), 32'(init_val(16'h0009)));
    chk("post-rst m0_rvalid", 32'(bus.m0_rvalid), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
